// File: rtl/prog_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : prog_loader                                             |
// | Description : Boot-time program loader. Parses framed, checksummed    |
// |               load records from a byte stream and writes 16-bit words |
// |               into the text or data memory, then releases the core    |
// |               with `run` on a GO command.                             |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module prog_loader (
  input  logic        clk,
  input  logic        reset,          // asynchronous, active-low
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we_text,
  output logic        mem_we_data,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        run,
  output logic        err,
  output logic [15:0] words_loaded
);

  // Frame target codes carried in the first byte of every record
  localparam logic [7:0]  c_TGT_TEXT = 8'h00;
  localparam logic [7:0]  c_TGT_DATA = 8'h01;
  localparam logic [7:0]  c_TGT_GO   = 8'hFF;
  localparam logic [15:0] c_SAT_MAX  = 16'hFFFF;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_ADDR_H = 4'd1,
    S_ADDR_L = 4'd2,
    S_CNT_H  = 4'd3,
    S_CNT_L  = 4'd4,
    S_WORD_H = 4'd5,
    S_WORD_L = 4'd6,
    S_CSUM   = 4'd7,
    S_RUN    = 4'd8,
    S_ERR    = 4'd9
  } state_t;

  state_t      r_state;
  logic        r_ready;
  logic        r_is_data;   // latched target: 0 = text, 1 = data
  logic [15:0] r_addr;      // next word address, wraps modulo 2^16
  logic [15:0] r_cnt;       // words remaining in the current frame
  logic [7:0]  r_hi;        // high byte of the word being assembled
  logic [7:0]  r_csum;      // running XOR of frame bytes
  logic        r_we_text;
  logic        r_we_data;
  logic [15:0] r_mem_addr;
  logic [15:0] r_mem_wdata;
  logic        r_run;
  logic        r_err;
  logic [15:0] r_words;

  logic        w_accept;
  logic [7:0]  w_csum_nxt;
  logic [15:0] w_cnt_full;
  logic [15:0] w_word;
  logic [15:0] w_words_inc;

  // Byte transfer qualifier and datapath helpers
  always_comb begin
    w_accept    = in_valid && r_ready;
    w_csum_nxt  = r_csum ^ in_data;
    w_cnt_full  = {r_cnt[15:8], in_data};
    w_word      = {r_hi, in_data};
    w_words_inc = (r_words == c_SAT_MAX) ? r_words : (r_words + 16'd1);
  end

  // Frame parser FSM with registered handshake, write port and status
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b0;
      r_is_data   <= 1'b0;
      r_addr      <= 16'h0000;
      r_cnt       <= 16'h0000;
      r_hi        <= 8'h00;
      r_csum      <= 8'h00;
      r_we_text   <= 1'b0;
      r_we_data   <= 1'b0;
      r_mem_addr  <= 16'h0000;
      r_mem_wdata <= 16'h0000;
      r_run       <= 1'b0;
      r_err       <= 1'b0;
      r_words     <= 16'h0000;
    end else begin
      // Strobes are single-cycle; parsing states always accept
      r_we_text <= 1'b0;
      r_we_data <= 1'b0;
      r_ready   <= 1'b1;

      if (w_accept) begin
        case (r_state)
          S_IDLE: begin
            // Accumulator was cleared on IDLE entry, so it starts at TGT
            r_csum <= in_data;
            if (in_data == c_TGT_TEXT || in_data == c_TGT_DATA) begin
              r_is_data <= in_data[0];
              r_state   <= S_ADDR_H;
            end else if (in_data == c_TGT_GO) begin
              r_run   <= 1'b1;
              r_ready <= 1'b0;
              r_state <= S_RUN;
            end else begin
              r_err   <= 1'b1;
              r_ready <= 1'b0;
              r_state <= S_ERR;
            end
          end

          S_ADDR_H: begin
            r_addr[15:8] <= in_data;
            r_csum       <= w_csum_nxt;
            r_state      <= S_ADDR_L;
          end

          S_ADDR_L: begin
            r_addr[7:0] <= in_data;
            r_csum      <= w_csum_nxt;
            r_state     <= S_CNT_H;
          end

          S_CNT_H: begin
            r_cnt[15:8] <= in_data;
            r_csum      <= w_csum_nxt;
            r_state     <= S_CNT_L;
          end

          S_CNT_L: begin
            r_cnt  <= w_cnt_full;
            r_csum <= w_csum_nxt;
            // An empty frame goes straight to its checksum byte
            r_state <= (w_cnt_full == 16'h0000) ? S_CSUM : S_WORD_H;
          end

          S_WORD_H: begin
            r_hi    <= in_data;
            r_csum  <= w_csum_nxt;
            r_state <= S_WORD_L;
          end

          S_WORD_L: begin
            r_csum      <= w_csum_nxt;
            r_we_text   <= ~r_is_data;
            r_we_data   <= r_is_data;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= w_word;
            r_words     <= w_words_inc;
            r_addr      <= r_addr + 16'd1;
            r_cnt       <= r_cnt - 16'd1;
            r_state     <= (r_cnt == 16'd1) ? S_CSUM : S_WORD_H;
          end

          S_CSUM: begin
            if (in_data == r_csum) begin
              r_csum  <= 8'h00;
              r_state <= S_IDLE;
            end else begin
              // Words already written stay written; only flag the error
              r_err   <= 1'b1;
              r_ready <= 1'b0;
              r_state <= S_ERR;
            end
          end

          default: begin
            r_ready <= 1'b0;
          end
        endcase
      end else if (r_state == S_RUN || r_state == S_ERR) begin
        // Terminal states never accept another byte
        r_ready <= 1'b0;
      end
    end
  end

  // Drive ports straight from registers
  always_comb begin
    in_ready     = r_ready;
    mem_we_text  = r_we_text;
    mem_we_data  = r_we_data;
    mem_addr     = r_mem_addr;
    mem_wdata    = r_mem_wdata;
    run          = r_run;
    err          = r_err;
    words_loaded = r_words;
  end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : tb_prog_loader                                          |
// | Description : Directed self-checking bench for prog_loader.           |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module tb_prog_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we_text;
  logic        mem_we_data;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        run;
  logic        err;
  logic [15:0] words_loaded;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_wt  = 0;   // text strobes seen
  int n_wd  = 0;   // data strobes seen
  int n_wide = 0;  // strobes high on two consecutive cycles
  logic prev_strobe = 1'b0;

  prog_loader dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_we_text  (mem_we_text),
    .mem_we_data  (mem_we_data),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .run          (run),
    .err          (err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_we_text) n_wt <= n_wt + 1;
    if (mem_we_data) n_wd <= n_wd + 1;
    if ((mem_we_text || mem_we_data) && prev_strobe) n_wide <= n_wide + 1;
    prev_strobe <= mem_we_text || mem_we_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one byte and return just after the edge that transfers it
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    assert (in_ready === 1'b1) else begin
      n_bad++;
      $error("FAIL send_timeout: byte 0x%0h in_ready observed %b required 1", b, in_ready);
    end
    if (in_ready) begin
      @(posedge clk);
      #1;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  // Same as send, but with a random number of idle cycles first
  task automatic send_stall(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'hA5;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    send(b);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int base;
  int c1;
  int c2;

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // ---- reset state ----
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_we_text", mem_we_text, 0);
    check("rst_we_data", mem_we_data, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_run", run, 0);
    check("rst_err", err, 0);
    check("rst_words", words_loaded, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rel_in_ready", in_ready, 1);

    // ---- text frame then GO ----
    base = n_wt;
    send(8'h00); send(8'h00); send(8'h00); send(8'h00); send(8'h01);
    send(8'h12); send(8'h34);
    check("t_we_text", mem_we_text, 1);
    check("t_we_data", mem_we_data, 0);
    check("t_addr", mem_addr, 16'h0000);
    check("t_wdata", mem_wdata, 16'h1234);
    send(8'h27);
    check("t_we_drop", mem_we_text, 0);
    check("t_nwrites", n_wt - base, 1);
    check("t_words", words_loaded, 1);
    check("t_err", err, 0);
    check("t_run_pre", run, 0);
    send(8'hFF);
    check("t_run", run, 1);
    check("t_run_ready", in_ready, 0);
    check("t_run_err", err, 0);
    check("t_hold_addr", mem_addr, 16'h0000);
    check("t_hold_wdata", mem_wdata, 16'h1234);

    // ---- data frame with address wrap ----
    do_reset();
    base = n_wd;
    send(8'h01); send(8'hFF); send(8'hFF); send(8'h00); send(8'h02);
    send(8'hAB); send(8'hCD);
    c1 = cyc;
    check("d_we_data0", mem_we_data, 1);
    check("d_we_text0", mem_we_text, 0);
    check("d_addr0", mem_addr, 16'hFFFF);
    check("d_wdata0", mem_wdata, 16'hABCD);
    send(8'h00);
    check("d_gap_low", mem_we_data, 0);
    send(8'h01);
    c2 = cyc;
    check("d_we_data1", mem_we_data, 1);
    check("d_addr1", mem_addr, 16'h0000);
    check("d_wdata1", mem_wdata, 16'h0001);
    check("d_gap", c2 - c1, 2);
    send(8'h64);
    check("d_nwrites", n_wd - base, 2);
    check("d_words", words_loaded, 2);
    check("d_err", err, 0);
    check("d_ready", in_ready, 1);

    // ---- bad checksum ----
    do_reset();
    base = n_wt;
    send(8'h00); send(8'h00); send(8'h00); send(8'h00); send(8'h01);
    send(8'h12); send(8'h34);
    check("c_we_text", mem_we_text, 1);
    check("c_wdata", mem_wdata, 16'h1234);
    check("c_err_pre", err, 0);
    send(8'h28);
    check("c_err", err, 1);
    check("c_ready", in_ready, 0);
    check("c_nwrites", n_wt - base, 1);
    @(negedge clk);
    in_data  = 8'hFF;
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("c_go_ready", in_ready, 0);
    check("c_go_run", run, 0);
    check("c_go_err", err, 1);
    idle();

    // ---- bad target ----
    do_reset();
    base = n_wt + n_wd;
    send(8'h05);
    check("b_err", err, 1);
    check("b_run", run, 0);
    check("b_ready", in_ready, 0);
    repeat (3) @(negedge clk);
    check("b_nwrites", n_wt + n_wd - base, 0);
    check("b_words", words_loaded, 0);

    // ---- zero count with random stalls ----
    do_reset();
    base = n_wt + n_wd;
    send_stall(8'h00); send_stall(8'h00); send_stall(8'h10);
    send_stall(8'h00); send_stall(8'h00);
    idle();
    repeat (7) @(negedge clk);
    check("z_stall_ready", in_ready, 1);
    send_stall(8'h10);
    idle();
    repeat (2) @(negedge clk);
    check("zs_nwrites", n_wt + n_wd - base, 0);
    check("zs_err", err, 0);
    check("zs_words", words_loaded, 0);
    check("zs_ready", in_ready, 1);
    send(8'hFF);
    check("zs_idle_go", run, 1);

    // ---- zero count back-to-back (same result expected) ----
    do_reset();
    base = n_wt + n_wd;
    send(8'h00); send(8'h00); send(8'h10); send(8'h00); send(8'h00); send(8'h10);
    idle();
    repeat (2) @(negedge clk);
    check("zb_nwrites", n_wt + n_wd - base, 0);
    check("zb_err", err, 0);
    check("zb_words", words_loaded, 0);
    check("zb_ready", in_ready, 1);
    send(8'hFF);
    check("zb_idle_go", run, 1);

    // ---- reset mid-frame, then resend ----
    do_reset();
    send(8'h00); send(8'h00); send(8'h00); send(8'h00); send(8'h01);
    send(8'h12);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    check("m_ready", in_ready, 0);
    check("m_we_text", mem_we_text, 0);
    check("m_words", words_loaded, 0);
    check("m_err", err, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    base = n_wt;
    send(8'h00); send(8'h00); send(8'h00); send(8'h00); send(8'h01);
    send(8'h12); send(8'h34);
    check("m_wdata", mem_wdata, 16'h1234);
    check("m_addr", mem_addr, 16'h0000);
    send(8'h27);
    check("m_nwrites", n_wt - base, 1);
    check("m_words1", words_loaded, 1);
    check("m_err1", err, 0);
    idle();

    check("strobe_width", n_wide, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
